// File: rtl/axis_hash_trailer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_hash_trailer
//  Purpose  : Registered AXI-Stream pass-through that appends a 32-bit
//             word-wise FNV-1a hash beat to every packet. The packet's tlast
//             moves onto the hash beat. Bypass mode, latched at packet
//             boundaries, forwards the stream untouched.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_hash_trailer #(
   parameter logic [31:0] HASH_INIT  = 32'h811C9DC5,
   parameter logic [31:0] HASH_PRIME = 32'h01000193
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        bypass,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [31:0] last_hash,
   output logic [31:0] pkt_count,
   output logic        bypass_active
);

   typedef enum logic [0:0] {
      ST_PASS    = 1'b0,
      ST_TRAILER = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        in_pkt_q, in_pkt_d;
   logic [31:0] hash_q, hash_d;
   logic [31:0] trail_hash_q, trail_hash_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic [31:0] last_hash_q, last_hash_d;
   logic [31:0] pkt_count_q, pkt_count_d;
   logic        bypass_active_q, bypass_active_d;

   logic        load_ok;
   logic        accept;
   logic [31:0] next_hash;

   // The output register may take a new beat when empty or draining this cycle.
   assign load_ok       = !out_valid_q || m_axis_tready;
   assign s_axis_tready = (state_q == ST_PASS) && load_ok;
   assign accept        = s_axis_tvalid && s_axis_tready;
   // Only the low 32 bits of the product are kept.
   assign next_hash     = (hash_q ^ s_axis_tdata) * HASH_PRIME;

   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tlast  = out_last_q;
   assign last_hash     = last_hash_q;
   assign pkt_count     = pkt_count_q;
   assign bypass_active = bypass_active_q;

   // Next-state logic: data forwarding, hash accumulation and trailer insertion.
   always_comb begin
      state_d         = state_q;
      in_pkt_d        = in_pkt_q;
      hash_d          = hash_q;
      trail_hash_d    = trail_hash_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_last_d      = out_last_q;
      last_hash_d     = last_hash_q;
      pkt_count_d     = pkt_count_q;
      bypass_active_d = bypass_active_q;

      if (state_q == ST_PASS) begin
         // Mode changes only take hold between packets.
         if (!in_pkt_q) begin
            bypass_active_d = bypass;
         end
         if (accept) begin
            in_pkt_d    = !s_axis_tlast;
            out_valid_d = 1'b1;
            out_data_d  = s_axis_tdata;
            if (bypass_active_q) begin
               out_last_d = s_axis_tlast;
               hash_d     = HASH_INIT;
            end else begin
               // tlast is withheld here and re-emitted on the trailer beat.
               out_last_d = 1'b0;
               if (s_axis_tlast) begin
                  trail_hash_d = next_hash;
                  hash_d       = HASH_INIT;
                  state_d      = ST_TRAILER;
               end else begin
                  hash_d = next_hash;
               end
            end
         end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
         end
      end else begin
         // Input is blocked for this state; the trailer goes out once there is room.
         if (load_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = trail_hash_q;
            out_last_d  = 1'b1;
            last_hash_d = trail_hash_q;
            pkt_count_d = pkt_count_q + 32'd1;
            state_d     = ST_PASS;
         end
      end
   end

   // State and datapath registers; reset discards any in-flight packet or trailer.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q         <= ST_PASS;
         in_pkt_q        <= 1'b0;
         hash_q          <= HASH_INIT;
         trail_hash_q    <= 32'd0;
         out_valid_q     <= 1'b0;
         out_data_q      <= 32'd0;
         out_last_q      <= 1'b0;
         last_hash_q     <= 32'd0;
         pkt_count_q     <= 32'd0;
         bypass_active_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         in_pkt_q        <= in_pkt_d;
         hash_q          <= hash_d;
         trail_hash_q    <= trail_hash_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_last_q      <= out_last_d;
         last_hash_q     <= last_hash_d;
         pkt_count_q     <= pkt_count_d;
         bypass_active_q <= bypass_active_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_hash_trailer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_hash_trailer
//  Purpose  : Self-checking bench for axis_hash_trailer. Output beats are
//             checked against a queue built from a word-wise FNV-1a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_hash_trailer;

   localparam logic [31:0] INIT  = 32'h811C9DC5;
   localparam logic [31:0] PRIME = 32'h01000193;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        bypass = 1'b0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [31:0] last_hash;
   logic [31:0] pkt_count;
   logic        bypass_active;

   axis_hash_trailer dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .bypass        (bypass),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .last_hash     (last_hash),
      .pkt_count     (pkt_count),
      .bypass_active (bypass_active)
   );

   always #5 aclk = ~aclk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [32:0] exp_q[$];       // {tlast, tdata} in expected output order
   logic [32:0] exp_b;
   bit          mon_en = 0;
   bit          rnd_rdy = 0;
   bit          cnt_en = 0;
   int          rdy_low = 0;
   int          out_beats = 0;
   bit          stall_prev = 0;
   logic [32:0] stall_val = '0;

   // Word-wise FNV-1a over a whole packet.
   function automatic logic [31:0] fnv(input logic [31:0] w[$]);
      logic [31:0] h;
      h = INIT;
      foreach (w[i]) h = (h ^ w[i]) * PRIME;
      return h;
   endfunction

   // Random sink readiness, changed just after each rising edge.
   always @(posedge aclk) begin
      #1;
      if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
   end

   // Output monitor: scoreboard pop on every handshake, stall stability, ready-low count.
   always @(negedge aclk) begin
      if (mon_en && aresetn) begin
         if (stall_prev) begin
            n_cmp++;
            if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== stall_val) begin
               n_err++;
               $display("FAIL stall_hold: got v=%b {last,data}=%h, need v=1 %h",
                        m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, stall_val);
            end
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         stall_val  = {m_axis_tlast, m_axis_tdata};
         if (m_axis_tvalid && m_axis_tready) begin
            out_beats++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL out_beat: got unexpected {last,data}=%h, need no beat",
                        {m_axis_tlast, m_axis_tdata});
            end else begin
               exp_b = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== exp_b) begin
                  n_err++;
                  $display("FAIL out_beat: got {last,data}=%h, need %h",
                           {m_axis_tlast, m_axis_tdata}, exp_b);
               end
            end
         end
         if (cnt_en && !s_axis_tready) rdy_low++;
      end else begin
         stall_prev = 0;
      end
   end

   task automatic drive_beat(input logic [31:0] d, input logic l, input int gap);
      int guard;
      repeat (gap) begin
         @(posedge aclk);
         #1;
      end
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      guard = 0;
      forever begin
         @(negedge aclk);
         if (s_axis_tready) break;
         guard++;
         if (guard > 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got s_axis_tready=0 for 2000 cycles, need 1");
            s_axis_tvalid = 1'b0;
            return;
         end
      end
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] w[$], input bit byp, input int max_gap);
      for (int i = 0; i < w.size(); i++)
         exp_q.push_back({(byp && (i == w.size() - 1)), w[i]});
      if (!byp) exp_q.push_back({1'b1, fnv(w)});
      for (int i = 0; i < w.size(); i++)
         drive_beat(w[i], (i == w.size() - 1), int'($urandom_range(0, max_gap)));
   endtask

   task automatic rand_pkt(input int len, output logic [31:0] w[$]);
      w = {};
      for (int i = 0; i < len; i++) w.push_back($urandom);
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 5000) begin
         @(negedge aclk);
         guard++;
      end
      repeat (4) @(negedge aclk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d beats still outstanding, need 0", exp_q.size());
         exp_q = {};
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      mon_en  = 0;
      #23;
      n_cmp += 6;
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b need 0", m_axis_tvalid); end
      if (m_axis_tdata !== 32'd0) begin n_err++; $display("FAIL rst_tdata: got %h need 0", m_axis_tdata); end
      if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b need 0", m_axis_tlast); end
      if (last_hash !== 32'd0) begin n_err++; $display("FAIL rst_last_hash: got %h need 0", last_hash); end
      if (pkt_count !== 32'd0) begin n_err++; $display("FAIL rst_pkt_count: got %h need 0", pkt_count); end
      if (bypass_active !== 1'b0) begin n_err++; $display("FAIL rst_bypass_active: got %b need 0", bypass_active); end
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      n_cmp++;
      if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b need 1", s_axis_tready); end
      mon_en = 1;
      @(posedge aclk);
      #1;
   endtask

   task automatic test_single_zero();
      logic [31:0] w[$];
      m_axis_tready = 1'b1;
      w = {32'd0};
      send_pkt(w, 0, 0);
      wait_drain();
      n_cmp += 2;
      if (last_hash !== 32'h050C5D1F) begin n_err++; $display("FAIL zero_last_hash: got %h need 050c5d1f", last_hash); end
      if (pkt_count !== 32'd1) begin n_err++; $display("FAIL zero_pkt_count: got %0d need 1", pkt_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a[$];
      logic [31:0] b[$];
      logic [31:0] base;
      base = pkt_count;
      m_axis_tready = 1'b1;
      rand_pkt(4, a);
      rand_pkt(4, b);
      out_beats = 0;
      rdy_low   = 0;
      cnt_en    = 1;
      send_pkt(a, 0, 0);
      send_pkt(b, 0, 0);
      wait_drain();
      cnt_en = 0;
      n_cmp += 4;
      if (out_beats != 10) begin n_err++; $display("FAIL b2b_beats: got %0d need 10", out_beats); end
      if (rdy_low != 2) begin n_err++; $display("FAIL b2b_tready_low: got %0d cycles need 2", rdy_low); end
      if (last_hash !== fnv(b)) begin n_err++; $display("FAIL b2b_last_hash: got %h need %h", last_hash, fnv(b)); end
      if (pkt_count !== base + 32'd2) begin n_err++; $display("FAIL b2b_pkt_count: got %0d need %0d", pkt_count, base + 32'd2); end
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      logic [31:0] base;
      logic [31:0] last_tr;
      base = pkt_count;
      last_tr = 32'd0;
      rnd_rdy = 1;
      for (int p = 0; p < 100; p++) begin
         rand_pkt(int'($urandom_range(1, 16)), w);
         last_tr = fnv(w);
         send_pkt(w, 0, 2);
      end
      wait_drain();
      rnd_rdy = 0;
      @(posedge aclk);
      #2;
      m_axis_tready = 1'b1;
      n_cmp += 2;
      if (pkt_count !== base + 32'd100) begin n_err++; $display("FAIL rand_pkt_count: got %0d need %0d", pkt_count, base + 32'd100); end
      if (last_hash !== last_tr) begin n_err++; $display("FAIL rand_last_hash: got %h need %h", last_hash, last_tr); end
   endtask

   task automatic test_bypass();
      logic [31:0] w[$];
      logic [31:0] base;
      m_axis_tready = 1'b1;
      bypass = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      base = pkt_count;
      n_cmp++;
      if (bypass_active !== 1'b1) begin n_err++; $display("FAIL byp_active: got %b need 1", bypass_active); end
      rand_pkt(3, w);
      send_pkt(w, 1, 0);
      wait_drain();
      n_cmp++;
      if (pkt_count !== base) begin n_err++; $display("FAIL byp_pkt_count: got %0d need %0d", pkt_count, base); end
      // Bypass packet with mode cleared after its first beat.
      rand_pkt(3, w);
      foreach (w[i]) exp_q.push_back({(i == 2), w[i]});
      drive_beat(w[0], 1'b0, 0);
      bypass = 1'b0;
      drive_beat(w[1], 1'b0, 0);
      drive_beat(w[2], 1'b1, 0);
      wait_drain();
      rand_pkt(2, w);
      send_pkt(w, 0, 0);
      wait_drain();
      n_cmp += 2;
      if (pkt_count !== base + 32'd1) begin n_err++; $display("FAIL byp_toggle_count: got %0d need %0d", pkt_count, base + 32'd1); end
      if (last_hash !== fnv(w)) begin n_err++; $display("FAIL byp_toggle_hash: got %h need %h", last_hash, fnv(w)); end
      // Hashed packet with mode set after its first beat.
      rand_pkt(2, w);
      foreach (w[i]) exp_q.push_back({1'b0, w[i]});
      exp_q.push_back({1'b1, fnv(w)});
      drive_beat(w[0], 1'b0, 0);
      bypass = 1'b1;
      drive_beat(w[1], 1'b1, 0);
      wait_drain();
      rand_pkt(2, w);
      send_pkt(w, 1, 0);
      wait_drain();
      n_cmp++;
      if (pkt_count !== base + 32'd2) begin n_err++; $display("FAIL byp_toggle2_count: got %0d need %0d", pkt_count, base + 32'd2); end
      bypass = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic test_reset_midpacket();
      logic [31:0] w[$];
      m_axis_tready = 1'b1;
      rand_pkt(5, w);
      exp_q.push_back({1'b0, w[0]});
      drive_beat(w[0], 1'b0, 0);
      drive_beat(w[1], 1'b0, 0);
      m_axis_tready = 1'b0;
      @(negedge aclk);
      n_cmp += 2;
      if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL mid_stalled: got tvalid=%b need 1", m_axis_tvalid); end
      if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_first_beat: got %0d outstanding need 0", exp_q.size()); end
      #2;
      aresetn = 1'b0;
      #1;
      n_cmp += 3;
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tvalid: got %b need 0", m_axis_tvalid); end
      if (m_axis_tdata !== 32'd0) begin n_err++; $display("FAIL mid_rst_tdata: got %h need 0", m_axis_tdata); end
      if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL mid_rst_tlast: got %b need 0", m_axis_tlast); end
      exp_q = {};
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      @(posedge aclk);
      #1;
      w = {32'd0};
      send_pkt(w, 0, 0);
      wait_drain();
      n_cmp += 2;
      if (last_hash !== 32'h050C5D1F) begin n_err++; $display("FAIL mid_after_hash: got %h need 050c5d1f", last_hash); end
      if (pkt_count !== 32'd1) begin n_err++; $display("FAIL mid_after_count: got %0d need 1", pkt_count); end
   endtask

   task automatic test_wrap();
      logic [31:0] w[$];
      @(negedge aclk);
      force dut.pkt_count_q = 32'hFFFFFFFF;
      #1;
      release dut.pkt_count_q;
      #1;
      n_cmp++;
      if (pkt_count !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_preset: got %h need ffffffff", pkt_count); end
      @(posedge aclk);
      #1;
      rand_pkt(2, w);
      send_pkt(w, 0, 0);
      wait_drain();
      n_cmp++;
      if (pkt_count !== 32'd0) begin n_err++; $display("FAIL wrap_count: got %h need 0", pkt_count); end
   endtask

   initial begin
      test_reset();
      test_single_zero();
      test_back_to_back();
      test_random();
      test_bypass();
      test_reset_midpacket();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no completion by 3 ms, need completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
